// File: rtl/vecmac_acc.sv
// Accumulates cfg_len beats per vector (saturating) for cfg_num vectors and
// queues {acc, sat} results in a small valid/ready FIFO; dropped pushes set ovf_err.
module vecmac_acc #(
   parameter int IN_W       = 19,
   parameter int ACC_W      = 32,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [LEN_W-1:0] cfg_num,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_sat,
   output logic             busy,
   output logic             ovf_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t           state_r;
   logic [LEN_W-1:0] len_r, num_r, beat_cnt_r, vec_cnt_r;
   logic [ACC_W-1:0] acc_r;
   logic             sat_r, busy_r, ovf_r, out_valid_r;
   logic [ACC_W-1:0] acc_mem_r [FIFO_DEPTH];
   logic             sat_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] count_r, count_nxt_s;

   logic [ACC_W:0]   sum_s;
   logic [ACC_W-1:0] clamp_s;
   logic             sat_nxt_s, start_ok_s, beat_s, last_s;
   logic             push_s, pop_s, full_s, push_ok_s, drop_s;

   assign start_ok_s = (state_r == IDLE) && start &&
                       (cfg_len != {LEN_W{1'b0}}) && (cfg_num != {LEN_W{1'b0}});
   assign beat_s     = (state_r == ACCUM) && in_valid;
   assign last_s     = (beat_cnt_r + LEN_ONE) == len_r;
   assign push_s     = beat_s && last_s;
   assign pop_s      = out_valid_r && out_ready;
   assign full_s     = (count_r == CNT_FULL);
   assign push_ok_s  = push_s && (!full_s || pop_s);
   assign drop_s     = push_s && full_s && !pop_s;

   // Saturating add of the incoming beat into the running accumulator.
   always_comb begin
      sum_s = {1'b0, acc_r} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
      if (sum_s[ACC_W]) begin
         clamp_s = {ACC_W{1'b1}};
      end else begin
         clamp_s = sum_s[ACC_W-1:0];
      end
      sat_nxt_s = sat_r | sum_s[ACC_W];
   end

   // Next FIFO occupancy from the push/pop pair of this cycle.
   always_comb begin
      count_nxt_s = count_r;
      if (push_ok_s && !pop_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (!push_ok_s && pop_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Job FSM: config latch, beat/vector counting, accumulator and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         len_r      <= {LEN_W{1'b0}};
         num_r      <= {LEN_W{1'b0}};
         beat_cnt_r <= {LEN_W{1'b0}};
         vec_cnt_r  <= {LEN_W{1'b0}};
         acc_r      <= {ACC_W{1'b0}};
         sat_r      <= 1'b0;
         busy_r     <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_ok_s) begin
                  len_r      <= cfg_len;
                  num_r      <= cfg_num;
                  beat_cnt_r <= {LEN_W{1'b0}};
                  vec_cnt_r  <= {LEN_W{1'b0}};
                  acc_r      <= {ACC_W{1'b0}};
                  sat_r      <= 1'b0;
                  ovf_r      <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ACCUM;
               end
            end
            ACCUM: begin
               if (beat_s && last_s) begin
                  acc_r      <= {ACC_W{1'b0}};
                  sat_r      <= 1'b0;
                  beat_cnt_r <= {LEN_W{1'b0}};
                  vec_cnt_r  <= vec_cnt_r + LEN_ONE;
                  if ((vec_cnt_r + LEN_ONE) == num_r) begin
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end else if (beat_s) begin
                  acc_r      <= clamp_s;
                  sat_r      <= sat_nxt_s;
                  beat_cnt_r <= beat_cnt_r + LEN_ONE;
               end
               if (drop_s) begin
                  ovf_r <= 1'b1;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Result FIFO storage and pointers; a full FIFO still accepts when popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            acc_mem_r[i] <= {ACC_W{1'b0}};
            sat_mem_r[i] <= 1'b0;
         end
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            acc_mem_r[wr_ptr_r] <= clamp_s;
            sat_mem_r[wr_ptr_r] <= sat_nxt_s;
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r     <= count_nxt_s;
         out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      end
   end

   assign out_valid = out_valid_r;
   assign out_acc   = acc_mem_r[rd_ptr_r];
   assign out_sat   = sat_mem_r[rd_ptr_r];
   assign busy      = busy_r;
   assign ovf_err   = ovf_r;

endmodule

// File: tb/tb_vecmac_acc.sv
// Scoreboard bench: two instances (ACC_W=32 and ACC_W=20) share stimulus; expected
// results are queued at stimulus time and popped by per-instance monitors.
module tb_vecmac_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_len = 16'd0;
   logic [15:0] cfg_num = 16'd0;
   logic        in_valid = 1'b0;
   logic [18:0] in_sum = 19'd0;
   logic        out_ready = 1'b1;

   logic        ov32, sat32, busy32, ovf32;
   logic [31:0] acc32;
   logic        ov20, sat20, busy20, ovf20;
   logic [19:0] acc20;

   int errors = 0;
   int checks = 0;
   logic [32:0] q32[$];
   logic [32:0] q20[$];

   always #5 clk = ~clk;

   vecmac_acc #(.IN_W(19), .ACC_W(32), .LEN_W(16), .FIFO_DEPTH(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
      .in_valid(in_valid), .in_sum(in_sum), .out_valid(ov32), .out_ready(out_ready),
      .out_acc(acc32), .out_sat(sat32), .busy(busy32), .ovf_err(ovf32));

   vecmac_acc #(.IN_W(19), .ACC_W(20), .LEN_W(16), .FIFO_DEPTH(4)) dut20 (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
      .in_valid(in_valid), .in_sum(in_sum), .out_valid(ov20), .out_ready(out_ready),
      .out_acc(acc20), .out_sat(sat20), .busy(busy20), .ovf_err(ovf20));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the 32-bit instance: every handshake pops one expectation.
   always @(negedge clk) begin
      if (rst_n && ov32 && out_ready) begin
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL unexpected32: got acc=%0d sat=%0d with nothing expected", acc32, sat32);
         end else begin
            logic [32:0] e;
            e = q32.pop_front();
            if ({sat32, acc32} !== e) begin
               errors++;
               $display("FAIL result32: got acc=%0d sat=%0d expected acc=%0d sat=%0d",
                        acc32, sat32, e[31:0], e[32]);
            end
         end
      end
   end

   // Monitor for the 20-bit instance.
   always @(negedge clk) begin
      if (rst_n && ov20 && out_ready) begin
         checks++;
         if (q20.size() == 0) begin
            errors++;
            $display("FAIL unexpected20: got acc=%0d sat=%0d with nothing expected", acc20, sat20);
         end else begin
            logic [32:0] e;
            e = q20.pop_front();
            if ({sat20, 12'd0, acc20} !== e) begin
               errors++;
               $display("FAIL result20: got acc=%0d sat=%0d expected acc=%0d sat=%0d",
                        acc20, sat20, e[31:0], e[32]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] len, input logic [15:0] num);
      start = 1'b1; cfg_len = len; cfg_num = num;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [18:0] v);
      in_valid = 1'b1; in_sum = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_both(input logic [31:0] v);
      q32.push_back({1'b0, v});
      q20.push_back({1'b0, v});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q32.size() != 0 || q20.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      chk(name, (n < 50) ? 64'd1 : 64'd0, 64'd1);
   endtask

   initial begin
      // Reset values
      #1;
      chk("rst_out_valid", ov32, 0);
      chk("rst_out_acc", acc32, 0);
      chk("rst_out_sat", sat32, 0);
      chk("rst_busy", busy32, 0);
      chk("rst_ovf", ovf32, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single beat, latency and busy timing
      do_start(16'd1, 16'd1);
      chk("t1_busy_after_start", busy32, 1);
      chk("t1_no_valid_before_beat", ov32, 0);
      expect_both(32'd520200);
      beat(19'd520200);
      chk("t1_valid_next_cycle", ov32, 1);
      chk("t1_busy_dropped", busy32, 0);
      tick();
      chk("t1_valid_one_cycle", ov32, 0);
      drain("t1_drain");

      // Multi-vector back-to-back
      do_start(16'd4, 16'd2);
      beat(19'd1); beat(19'd2); beat(19'd3);
      expect_both(32'd10);
      beat(19'd4);
      beat(19'd10); beat(19'd20); beat(19'd30);
      expect_both(32'd100);
      beat(19'd40);
      chk("t2_idle_after_job", busy32, 0);
      drain("t2_drain");

      // Saturation (20-bit instance clamps, 32-bit one does not)
      do_start(16'd3, 16'd2);
      beat(19'd520200); beat(19'd520200);
      q32.push_back({1'b0, 32'd1560600});
      q20.push_back({1'b1, 32'd1048575});
      beat(19'd520200);
      beat(19'd5); beat(19'd5);
      expect_both(32'd15);
      beat(19'd5);
      drain("t3_drain");

      // Backpressure and overflow
      out_ready = 1'b0;
      do_start(16'd1, 16'd6);
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) expect_both(32'(i));
         beat(19'(i));
         if (i == 4) chk("t4_ovf_before_drop", ovf32, 0);
         if (i == 5) chk("t4_ovf_on_drop", ovf32, 1);
      end
      chk("t4_busy_done", busy32, 0);
      tick(); tick();
      chk("t4_head_held", acc32, 1);
      chk("t4_valid_held", ov32, 1);
      out_ready = 1'b1;
      drain("t4_drain");
      tick();
      chk("t4_valid_fell", ov32, 0);
      chk("t4_ovf_sticky", ovf32, 1);

      // Illegal start, idle beats, mid-job start
      do_start(16'd0, 16'd1);
      chk("t5_zero_len_busy", busy32, 0);
      chk("t5_zero_len_ovf_kept", ovf32, 1);
      beat(19'd9); beat(19'd9); beat(19'd9);
      tick();
      chk("t5_idle_beats_ignored", ov32, 0);
      do_start(16'd2, 16'd1);
      chk("t5_ovf_cleared", ovf32, 0);
      beat(19'd5);
      do_start(16'd1, 16'd3);
      expect_both(32'd11);
      beat(19'd6);
      chk("t5_job_done_orig_cfg", busy32, 0);
      drain("t5_drain");
      tick();
      chk("t5_no_extra_results", ov32, 0);

      // Reset mid-vector with a stranded result in the FIFO
      out_ready = 1'b0;
      do_start(16'd4, 16'd2);
      beat(19'd1); beat(19'd1); beat(19'd1); beat(19'd1);
      chk("t6_fifo_loaded", ov32, 1);
      beat(19'd3); beat(19'd4);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", ov32, 0);
      chk("t6_rst_acc", acc32, 0);
      chk("t6_rst_busy", busy32, 0);
      chk("t6_rst_valid20", ov20, 0);
      tick(); tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      beat(19'd9);
      tick();
      chk("t6_post_reset_beat_ignored", ov32, 0);
      do_start(16'd2, 16'd1);
      beat(19'd7);
      expect_both(32'd15);
      beat(19'd8);
      drain("t6_drain");
      tick();
      chk("t6_queue32_empty", 64'(q32.size()), 0);
      chk("t6_queue20_empty", 64'(q20.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vecmac_acc.md
# vecmac_acc

Downstream accumulation stage for the int8 vector-MAC datapath. It consumes the 19-bit per-beat dot-product stream from the 8-lane Wallace multiplier (`in_valid`/sum, no backpressure). It sums `cfg_len` consecutive beats into one saturating `ACC_W`-bit result per vector, for `cfg_num` vectors per job. Results leave through a small FIFO with a valid/ready handshake, because the multiplier cannot be stalled.

## Interface
- `IN_W`, default 19: width of the incoming per-beat sum. Maximum input value is 8·255·255 = 520200.
- `ACC_W`, default 32: accumulator and result width.
- `LEN_W`, default 16: width of `cfg_len` and `cfg_num`.
- `FIFO_DEPTH`, default 4: result FIFO entries. Must be a power of two, ≥ 2.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle job start pulse.
- `cfg_len`, in, LEN_W: beats per vector; sampled on an accepted `start`.
- `cfg_num`, in, LEN_W: vectors per job; sampled on an accepted `start`.
- `in_valid`, in, 1: incoming beat valid; no ready is returned.
- `in_sum`, in, IN_W: incoming beat value, unsigned.
- `out_valid`, out, 1: result available at the FIFO head.
- `out_ready`, in, 1: consumer accepts the head result.
- `out_acc`, out, ACC_W: head result.
- `out_sat`, out, 1: head result saturated.
- `busy`, out, 1: job in progress.
- `ovf_err`, out, 1: sticky flag; one or more results were dropped because the FIFO was full.

## Operation
- FSM has two states: IDLE and ACCUM. Reset state is IDLE.
- In IDLE, `start` is accepted only when `cfg_len != 0` and `cfg_num != 0`.
  - On acceptance: latch both config values, clear `acc`, the beat counter, the vector counter and `ovf_err`, then go to ACCUM.
  - Otherwise `start` is ignored and no state changes.
- `start` while in ACCUM is ignored.
- `in_valid` while in IDLE is ignored. `in_valid` in the same cycle as an accepted `start` is also ignored.
- In ACCUM, each `in_valid` beat does the following:
  - Compute `sum = acc + in_sum` in ACC_W+1 bits.
  - If `sum` exceeds 2^ACC_W−1, clamp it to all-ones and set the per-vector sat bit. Once set, sat stays set for the rest of that vector.
  - Increment the beat counter.
- On the beat where the beat counter reaches `cfg_len` (the last beat):
  - Push {clamped sum, sat} to the FIFO.
  - Clear `acc`, the sat bit and the beat counter, so the next vector starts clean on the following beat.
  - Increment the vector counter.
  - If the vector counter reaches `cfg_num`, return to IDLE.
- FIFO push rules:
  - A push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - If the FIFO is full and there is no pop, the result is dropped and `ovf_err` is set. Accumulation is unaffected.
- FIFO pop: a pop occurs when `out_valid && out_ready`. The head advances on that edge.
- Pointer arithmetic wraps modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- `out_acc` and `out_sat` are held stable while `out_valid && !out_ready`.
- Reset mid-job (`rst_n` low at any time): the FIFO is emptied and all results are lost. The FSM goes to IDLE and every counter and flag clears. Beats arriving after reset is released are ignored until a new `start`.

## Timing
- Reset values: `out_valid`=0, `out_acc`=0, `out_sat`=0, `busy`=0, `ovf_err`=0.
- Earliest first beat is the cycle after `start`.
- `busy` goes to 1 on the edge that accepts `start`. It returns to 0 on the edge that consumes the final beat of the last vector.
- Result latency: the last beat is sampled at edge N and `out_valid`=1 after edge N, i.e. visible in cycle N+1. This holds when the FIFO was empty.
- Full-rate input (one beat per cycle, continuous) must be sustained with no bubble between vectors.
- With `cfg_len`=1, one result is pushed per beat. With `out_ready` held high, throughput is one result per cycle and the FIFO never fills.
- `ovf_err` rises on the edge of the dropped push. It holds until the next accepted `start` or reset.

## Test plan
- Single beat: `cfg_len`=1, `cfg_num`=1, one beat with `in_sum`=520200, `out_ready`=1 → one result with `out_acc`=520200 and `out_sat`=0. `busy` drops after that beat; `out_valid` is seen exactly one cycle after the beat.
- Multi-vector, back-to-back: `cfg_len`=4, `cfg_num`=2, beats 1,2,3,4,10,20,30,40 on consecutive cycles → results 10 then 100, both with `out_sat`=0, and the FSM ends in IDLE.
- Saturation with `ACC_W`=20: `cfg_len`=3, three beats of 520200 (true sum 1560600) → `out_acc`=1048575, `out_sat`=1. A following vector of beats 5,5,5 → `out_acc`=15, `out_sat`=0.
- Backpressure and overflow: `out_ready`=0, `cfg_len`=1, `cfg_num`=6, beats 1..6 → the FIFO holds 1,2,3,4, results 5 and 6 are dropped, and `ovf_err`=1. Then set `out_ready`=1 → outputs 1,2,3,4 in order and `out_valid` falls; `ovf_err` stays 1 until the next `start`.
- Illegal and ignored controls:
  - `start` with `cfg_len`=0 → `busy` stays 0.
  - `in_valid` beats while in IDLE → no results are produced.
  - `start` pulsed mid-job → the job completes with the original config.
- Reset mid-vector: `cfg_len`=4, two beats, then `rst_n` low for 2 cycles → all outputs return to reset values and the FIFO is empty. A new job with `cfg_len`=2 and beats 7,8 → result 15.
